cfglut_loader: RTL and testbench
================================

CFGLUT_LOADER -- requirements
Module: cfglut_loader

Interface
REQ-001 SHALL have parameter NUM_LUT, default 10: number of CFGLUT5 primitives driven.
REQ-002 SHALL have parameter LUT_BITS, default 32: bits shifted per load; legal values 2..32.
REQ-003 SHALL have port clk  in  1  sole clock; reset is synchronous and active-high.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  in  1  load request present.
REQ-006 SHALL have port req_ready  out  1  block can accept a request.
REQ-007 SHALL have port req_data  in  LUT_BITS  table contents, MSB shifted first.
REQ-008 SHALL have port req_mask  in  NUM_LUT  LUTs to load; bit i drives CE[i].
REQ-009 SHALL have port cdi  out  1  serial data to all CFGLUT5 CDI pins.
REQ-010 SHALL have port ce  out  NUM_LUT  per-LUT clock enable.
REQ-011 SHALL have port cdo  in  NUM_LUT  CFGLUT5 CDO pins, one per LUT.
REQ-012 SHALL have port busy  out  1  high while a load is in progress.
REQ-013 SHALL have port done  out  1  one-cycle pulse when a load completes.
REQ-014 SHALL have port rdback_data  out  LUT_BITS  previous contents of the lowest-index masked LUT.

Function
REQ-015 SHALL use states IDLE, SHIFT and FINISH.
REQ-016 SHALL assert req_ready only in IDLE; a request is accepted on a clk edge with req_valid && req_ready.
REQ-017 SHALL, on accepting a request with nonzero mask, register req_data and req_mask, load the bit counter with LUT_BITS-1 and enter SHIFT.
REQ-018 SHALL, in SHIFT, drive ce = registered mask and cdi = shift-register MSB, shifting left one bit per cycle, for exactly LUT_BITS consecutive cycles.
REQ-019 SHALL, after the shift cycle with counter 0, drive ce to all-zero and enter FINISH.
REQ-020 SHALL, in FINISH, pulse done for one cycle, then return to IDLE.
REQ-021 SHALL give latency from accept edge to done high of LUT_BITS+1 cycles; back-to-back requests allow one request every LUT_BITS+2 cycles.
REQ-022 SHALL treat an accepted request with all-zero mask as a no-op: no ce assertion, go directly to FINISH, done pulses on the next cycle.
REQ-023 SHALL keep cdi at 0 and ce at all-zero whenever state is not SHIFT.
REQ-024 SHALL hold busy high in SHIFT and FINISH, low in IDLE.
REQ-025 SHALL ignore changes on req_data, req_mask and req_valid while not in IDLE.

Reset
REQ-026 SHALL, on reset, enter IDLE and drive ce=0, cdi=0, done=0, busy=0, req_ready=0 during reset, then req_ready=1 on the first cycle after reset.
REQ-027 SHALL clear rdback_data to 0 on reset.
REQ-028 SHALL, on reset during SHIFT or FINISH, abort the load with ce=0 on the next edge and no done pulse.

Configuration
REQ-029 SHALL recognise macro CFGLUT_READBACK_EN.
REQ-030 SHALL, with CFGLUT_READBACK_EN defined, sample cdo of the lowest-index masked LUT on every SHIFT cycle into a shift register (first sample at MSB) and update rdback_data on the cycle done is asserted; unchanged for zero-mask no-ops.
REQ-031 SHALL, without CFGLUT_READBACK_EN, ignore cdo and tie rdback_data to 0; the port list is identical in both builds.

Structure
REQ-032 SHALL place the state enum and constant CFGLUT5_BITS=32 in package cfglut_pkg.
REQ-033 SHALL size the bit counter as $clog2(LUT_BITS) bits.
REQ-034 SHALL implement the readback priority-select and capture as sub-module cfglut_readback, instantiated only under CFGLUT_READBACK_EN.

Verification
REQ-035 SHALL cover: req_data=32'h8000_0001, mask=10'h001 -> ce[0] high 32 cycles; cdi=1 on first and last cycles, 0 otherwise; done 33 cycles after accept.
REQ-036 SHALL cover: mask=10'h3FF -> all ce bits high together for 32 cycles; req_ready low throughout; done pulses once.
REQ-037 SHALL cover: req_valid held high with two queued requests -> second accept exactly 34 cycles after the first; no ce gap overlap.
REQ-038 SHALL cover: mask=10'h000 -> ce never asserts; done 1 cycle after accept.
REQ-039 SHALL cover: reset asserted on shift cycle 10 -> ce=0 next cycle, no done, req_ready=1 after reset release.
REQ-040 SHALL cover (CFGLUT_READBACK_EN): LUT model preloaded 32'hDEAD_BEEF, mask=10'h004 -> rdback_data=32'hDEAD_BEEF when done pulses.

Source files
------------

// File: rtl/cfglut_pkg.sv
// Shared types and constants for the CFGLUT5 reconfiguration loader.
package cfglut_pkg;

  localparam int unsigned CFGLUT5_BITS = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } cfglut_state_e;

endpackage

// File: rtl/cfglut_readback.sv
// Readback capture for the CFGLUT5 loader: follows CDO of the lowest-index
// selected LUT while shifting and publishes the captured word when the load
// finishes. Only instantiated when CFGLUT_READBACK_EN is defined.
module cfglut_readback
  import cfglut_pkg::*;
#(
  parameter int unsigned NUM_LUT  = 10,
  parameter int unsigned LUT_BITS = CFGLUT5_BITS
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                shift_en_i,
  input  logic                commit_i,
  input  logic [NUM_LUT-1:0]  lut_sel_i,
  input  logic [NUM_LUT-1:0]  cdo_i,
  output logic [LUT_BITS-1:0] rdback_data_o
);

  logic                cdo_sel;
  logic [LUT_BITS-1:0] cap_q;
  logic [LUT_BITS-1:0] rdback_q;
  logic                valid_q;

  // Priority select: scanning high to low lets the lowest selected index win.
  always_comb begin
    cdo_sel = 1'b0;
    for (int unsigned i = 0; i < NUM_LUT; i++) begin
      if (lut_sel_i[NUM_LUT-1-i]) cdo_sel = cdo_i[NUM_LUT-1-i];
    end
  end

  // Capture one CDO bit per shift cycle (first sample ends at MSB); publish on finish.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cap_q    <= '0;
      rdback_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (shift_en_i) begin
        cap_q   <= {cap_q[LUT_BITS-2:0], cdo_sel};
        valid_q <= 1'b1;
      end
      // valid_q keeps zero-mask loads (no shift cycles) from touching the result.
      if (commit_i && valid_q) begin
        rdback_q <= cap_q;
        valid_q  <= 1'b0;
      end
    end
  end

  assign rdback_data_o = rdback_q;

endmodule

// File: rtl/cfglut_loader.sv
// CFGLUT5 reconfiguration loader: serialises a LUT_BITS-wide table MSB-first
// onto the shared CDI line while asserting CE on the selected LUTs.
// Optional build macro CFGLUT_READBACK_EN enables capture of the previous
// contents of the lowest-index selected LUT via its CDO pin.
module cfglut_loader
  import cfglut_pkg::*;
#(
  parameter int unsigned NUM_LUT  = 10,
  parameter int unsigned LUT_BITS = CFGLUT5_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [LUT_BITS-1:0] req_data,
  input  logic [NUM_LUT-1:0]  req_mask,
  output logic                cdi,
  output logic [NUM_LUT-1:0]  ce,
  input  logic [NUM_LUT-1:0]  cdo,
  output logic                busy,
  output logic                done,
  output logic [LUT_BITS-1:0] rdback_data
);

  localparam int unsigned CNT_W = $clog2(LUT_BITS);

  cfglut_state_e       state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [LUT_BITS-1:0] sr_q;
  logic [NUM_LUT-1:0]  ce_q;
  logic                cdi_q;
  logic                req_ready_q;
  logic                busy_q;
  logic                done_q;

  // Load sequencer; ce_q doubles as the registered request mask during SHIFT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      ce_q        <= '0;
      cdi_q       <= 1'b0;
      req_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (|req_mask) begin
              state_q <= SHIFT;
              cnt_q   <= CNT_W'(LUT_BITS - 1);
              cdi_q   <= req_data[LUT_BITS-1];
              sr_q    <= {req_data[LUT_BITS-2:0], 1'b0};
              ce_q    <= req_mask;
            end else begin
              state_q <= FINISH;
            end
          end
        end
        SHIFT: begin
          if (cnt_q == '0) begin
            state_q <= FINISH;
            ce_q    <= '0;
            cdi_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
            cdi_q <= sr_q[LUT_BITS-1];
            sr_q  <= {sr_q[LUT_BITS-2:0], 1'b0};
          end
        end
        FINISH: begin
          state_q     <= IDLE;
          done_q      <= 1'b1;
          busy_q      <= 1'b0;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ce_q    <= '0;
          cdi_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign cdi       = cdi_q;
  assign ce        = ce_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef CFGLUT_READBACK_EN
  cfglut_readback #(
    .NUM_LUT  (NUM_LUT),
    .LUT_BITS (LUT_BITS)
  ) u_readback (
    .clk_i         (clk),
    .reset_i       (reset),
    .shift_en_i    (state_q == SHIFT),
    .commit_i      (state_q == FINISH),
    .lut_sel_i     (ce_q),
    .cdo_i         (cdo),
    .rdback_data_o (rdback_data)
  );
`else
  logic unused_cdo;
  assign unused_cdo  = ^cdo;
  assign rdback_data = '0;
`endif

endmodule

// File: tb/tb_cfglut_loader.sv
// Directed testbench for cfglut_loader with a behavioural CFGLUT5 model.
// Readback scenarios are compiled when CFGLUT_READBACK_EN is defined.
module tb_cfglut_loader;

  localparam int NUM_LUT  = 10;
  localparam int LUT_BITS = 32;

  logic                clk = 1'b0;
  logic                reset;
  logic                req_valid;
  logic                req_ready;
  logic [LUT_BITS-1:0] req_data;
  logic [NUM_LUT-1:0]  req_mask;
  logic                cdi;
  logic [NUM_LUT-1:0]  ce;
  logic [NUM_LUT-1:0]  cdo;
  logic                busy;
  logic                done;
  logic [LUT_BITS-1:0] rdback_data;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  cfglut_loader #(
    .NUM_LUT  (NUM_LUT),
    .LUT_BITS (LUT_BITS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_data    (req_data),
    .req_mask    (req_mask),
    .cdi         (cdi),
    .ce          (ce),
    .cdo         (cdo),
    .busy        (busy),
    .done        (done),
    .rdback_data (rdback_data)
  );

  always #5 clk = ~clk;

  // CFGLUT5 model: shifts CDI in at the LSB when CE is high, CDO is the MSB.
  logic [31:0] lut_mem [NUM_LUT];
  logic        pre_en  = 1'b0;
  int          pre_idx = 0;
  logic [31:0] pre_val = '0;

  always @(posedge clk) begin
    for (int i = 0; i < NUM_LUT; i++) begin
      if (ce[i]) lut_mem[i] <= {lut_mem[i][30:0], cdi};
    end
    if (pre_en) lut_mem[pre_idx] <= pre_val;
  end

  always_comb begin
    for (int i = 0; i < NUM_LUT; i++) cdo[i] = lut_mem[i][31];
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    n_checks++; if (ce !== '0) $display("FAIL rst_ce got %h want 000", ce); else n_pass++;
    n_checks++; if (cdi !== 1'b0) $display("FAIL rst_cdi got %b want 0", cdi); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL rst_done got %b want 0", done); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (req_ready !== 1'b0) $display("FAIL rst_ready got %b want 0", req_ready); else n_pass++;
    n_checks++; if (rdback_data !== '0) $display("FAIL rst_rdback got %h want 0", rdback_data); else n_pass++;
    reset = 1'b0;
    tick();
    n_checks++; if (req_ready !== 1'b1) $display("FAIL rst_release_ready got %b want 1", req_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_release_busy got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_single;
    logic [31:0] d;
    d = 32'h8000_0001;
    req_data  = d;
    req_mask  = 10'h001;
    req_valid = 1'b1;
    tick();
    // Scrambled inputs while busy must have no effect.
    req_valid = 1'b0;
    req_data  = 32'h0F0F_0F0F;
    req_mask  = 10'h3FF;
    for (int k = 0; k < 32; k++) begin
      n_checks++; if (ce !== 10'h001) $display("FAIL single_ce k=%0d got %h want 001", k, ce); else n_pass++;
      n_checks++; if (cdi !== d[31-k]) $display("FAIL single_cdi k=%0d got %b want %b", k, cdi, d[31-k]); else n_pass++;
      n_checks++; if (done !== 1'b0 || busy !== 1'b1 || req_ready !== 1'b0)
        $display("FAIL single_ctl k=%0d got done=%b busy=%b ready=%b want 0/1/0", k, done, busy, req_ready);
      else n_pass++;
      tick();
    end
    n_checks++; if (ce !== '0 || cdi !== 1'b0) $display("FAIL single_fin_lines got ce=%h cdi=%b want 000/0", ce, cdi); else n_pass++;
    n_checks++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL single_fin_ctl got busy=%b done=%b want 1/0", busy, done); else n_pass++;
    tick();
    n_checks++; if (done !== 1'b1) $display("FAIL single_done_at33 got %b want 1", done); else n_pass++;
    n_checks++; if (busy !== 1'b0 || req_ready !== 1'b1) $display("FAIL single_idle got busy=%b ready=%b want 0/1", busy, req_ready); else n_pass++;
    n_checks++; if (lut_mem[0] !== d) $display("FAIL single_lut0 got %h want %h", lut_mem[0], d); else n_pass++;
`ifndef CFGLUT_READBACK_EN
    n_checks++; if (rdback_data !== '0) $display("FAIL single_rdback_tied got %h want 0", rdback_data); else n_pass++;
`endif
    tick();
    n_checks++; if (done !== 1'b0) $display("FAIL single_done_pulse got %b want 0", done); else n_pass++;
  endtask

  task automatic test_full_mask;
    logic [31:0] d;
    d = 32'hA5C3_0FF0;
    req_data  = d;
    req_mask  = 10'h3FF;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 32; k++) begin
      n_checks++; if (ce !== 10'h3FF) $display("FAIL full_ce k=%0d got %h want 3ff", k, ce); else n_pass++;
      n_checks++; if (cdi !== d[31-k]) $display("FAIL full_cdi k=%0d got %b want %b", k, cdi, d[31-k]); else n_pass++;
      n_checks++; if (req_ready !== 1'b0 || done !== 1'b0) $display("FAIL full_ctl k=%0d got ready=%b done=%b want 0/0", k, req_ready, done); else n_pass++;
      tick();
    end
    n_checks++; if (ce !== '0) $display("FAIL full_ce_off got %h want 000", ce); else n_pass++;
    tick();
    n_checks++; if (done !== 1'b1) $display("FAIL full_done got %b want 1", done); else n_pass++;
    tick();
    n_checks++; if (done !== 1'b0) $display("FAIL full_done_once got %b want 0", done); else n_pass++;
    for (int i = 0; i < NUM_LUT; i++) begin
      n_checks++; if (lut_mem[i] !== d) $display("FAIL full_lut i=%0d got %h want %h", i, lut_mem[i], d); else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d1, d2;
    logic [9:0]  m1, m2;
    int          acc2, first_done, last_done, dones;
    logic        prev_busy;
    d1 = 32'h1234_5678; m1 = 10'h0F0;
    d2 = 32'hCAFE_F00D; m2 = 10'h30F;
    acc2 = -1; first_done = -1; last_done = -1; dones = 0; prev_busy = 1'b1;
    req_data  = d1;
    req_mask  = m1;
    req_valid = 1'b1;
    tick();
    req_data = d2;
    req_mask = m2;
    for (int k = 0; k < 72; k++) begin
      if (k < 32) begin
        n_checks++; if (ce !== m1 || cdi !== d1[31-k])
          $display("FAIL b2b_first k=%0d got ce=%h cdi=%b want %h/%b", k, ce, cdi, m1, d1[31-k]);
        else n_pass++;
      end
      if (k == 32 || k == 33) begin
        n_checks++; if (ce !== '0) $display("FAIL b2b_gap k=%0d got %h want 000", k, ce); else n_pass++;
      end
      if (acc2 < 0 && !prev_busy && busy) begin
        acc2 = k;
        req_valid = 1'b0;
      end
      if (acc2 >= 0 && k < acc2 + 32) begin
        n_checks++; if (ce !== m2 || cdi !== d2[31-(k-acc2)])
          $display("FAIL b2b_second k=%0d got ce=%h cdi=%b want %h/%b", k, ce, cdi, m2, d2[31-(k-acc2)]);
        else n_pass++;
      end
      if (done) begin
        dones++;
        if (first_done < 0) first_done = k;
        last_done = k;
      end
      prev_busy = busy;
      tick();
    end
    req_valid = 1'b0;
    n_checks++; if (acc2 !== 34) $display("FAIL b2b_accept_spacing got %0d want 34", acc2); else n_pass++;
    n_checks++; if (dones !== 2) $display("FAIL b2b_done_count got %0d want 2", dones); else n_pass++;
    n_checks++; if (first_done !== 33) $display("FAIL b2b_done1 got %0d want 33", first_done); else n_pass++;
    n_checks++; if (last_done !== 67) $display("FAIL b2b_done2 got %0d want 67", last_done); else n_pass++;
    n_checks++; if (lut_mem[4] !== d1) $display("FAIL b2b_lut4 got %h want %h", lut_mem[4], d1); else n_pass++;
    n_checks++; if (lut_mem[0] !== d2) $display("FAIL b2b_lut0 got %h want %h", lut_mem[0], d2); else n_pass++;
    n_checks++; if (lut_mem[9] !== d2) $display("FAIL b2b_lut9 got %h want %h", lut_mem[9], d2); else n_pass++;
  endtask

  task automatic test_zero_mask;
    req_data  = 32'hFFFF_FFFF;
    req_mask  = 10'h000;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    n_checks++; if (ce !== '0 || cdi !== 1'b0) $display("FAIL zero_lines got ce=%h cdi=%b want 000/0", ce, cdi); else n_pass++;
    n_checks++; if (busy !== 1'b1 || req_ready !== 1'b0 || done !== 1'b0)
      $display("FAIL zero_finish got busy=%b ready=%b done=%b want 1/0/0", busy, req_ready, done);
    else n_pass++;
    tick();
    n_checks++; if (done !== 1'b1) $display("FAIL zero_done got %b want 1", done); else n_pass++;
    n_checks++; if (ce !== '0 || busy !== 1'b0) $display("FAIL zero_after got ce=%h busy=%b want 000/0", ce, busy); else n_pass++;
    tick();
    n_checks++; if (done !== 1'b0 || req_ready !== 1'b1) $display("FAIL zero_idle got done=%b ready=%b want 0/1", done, req_ready); else n_pass++;
    n_checks++; if (lut_mem[0] !== 32'hCAFE_F00D) $display("FAIL zero_lut0 got %h want cafef00d", lut_mem[0]); else n_pass++;
  endtask

  task automatic test_reset_abort;
    int dones;
    logic ce_seen;
    dones = 0; ce_seen = 1'b0;
    req_data  = 32'hFFFF_FFFF;
    req_mask  = 10'h155;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    n_checks++; if (ce !== 10'h155) $display("FAIL abort_ce_before got %h want 155", ce); else n_pass++;
    reset = 1'b1;
    tick();
    n_checks++; if (ce !== '0 || cdi !== 1'b0) $display("FAIL abort_lines got ce=%h cdi=%b want 000/0", ce, cdi); else n_pass++;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0 || req_ready !== 1'b0)
      $display("FAIL abort_ctl got busy=%b done=%b ready=%b want 0/0/0", busy, done, req_ready);
    else n_pass++;
    reset = 1'b0;
    tick();
    n_checks++; if (req_ready !== 1'b1) $display("FAIL abort_ready got %b want 1", req_ready); else n_pass++;
    for (int k = 0; k < 40; k++) begin
      if (done) dones++;
      if (ce !== '0) ce_seen = 1'b1;
      tick();
    end
    n_checks++; if (dones !== 0) $display("FAIL abort_no_done got %0d pulses want 0", dones); else n_pass++;
    n_checks++; if (ce_seen !== 1'b0) $display("FAIL abort_ce_quiet got %b want 0", ce_seen); else n_pass++;
  endtask

`ifdef CFGLUT_READBACK_EN
  task automatic test_readback;
    int got;
    pre_en = 1'b1; pre_idx = 2; pre_val = 32'hDEAD_BEEF;
    tick();
    pre_en = 1'b0;
    req_data  = 32'h0123_4567;
    req_mask  = 10'h004;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    got = -1;
    for (int k = 0; k < 40 && got < 0; k++) begin
      if (done) begin
        got = k;
        n_checks++; if (rdback_data !== 32'hDEAD_BEEF) $display("FAIL rb_value got %h want deadbeef", rdback_data); else n_pass++;
      end else tick();
    end
    n_checks++; if (got !== 33) $display("FAIL rb_done_latency got %0d want 33", got); else n_pass++;
    n_checks++; if (lut_mem[2] !== 32'h0123_4567) $display("FAIL rb_lut2 got %h want 01234567", lut_mem[2]); else n_pass++;
    tick();
    // LUT2 and LUT3 selected: the lower index supplies the readback.
    req_data  = 32'h89AB_CDEF;
    req_mask  = 10'h00C;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    got = -1;
    for (int k = 0; k < 40 && got < 0; k++) begin
      if (done) begin
        got = k;
        n_checks++; if (rdback_data !== 32'h0123_4567) $display("FAIL rb_priority got %h want 01234567", rdback_data); else n_pass++;
      end else tick();
    end
    n_checks++; if (got !== 33) $display("FAIL rb_priority_latency got %0d want 33", got); else n_pass++;
    tick();
    req_data  = 32'h5555_AAAA;
    req_mask  = 10'h000;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    n_checks++; if (done !== 1'b1) $display("FAIL rb_zero_done got %b want 1", done); else n_pass++;
    n_checks++; if (rdback_data !== 32'h0123_4567) $display("FAIL rb_zero_hold got %h want 01234567", rdback_data); else n_pass++;
    tick();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_data  = '0;
    req_mask  = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_full_mask();
    test_back_to_back();
    test_zero_mask();
    test_reset_abort();
`ifdef CFGLUT_READBACK_EN
    test_readback();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
